// File: rtl/hex_display_scanner_pkg.sv
// Shared constants and nibble helpers for the hex display scanner.
// Helpers take words zero-extended to MAX_WIDTH so any legal WIDTH can use them.
package hex_display_scanner_pkg;

  localparam int NIBBLE_W   = 4;
  localparam int MAX_WIDTH  = 64;
  localparam int MAX_DIGITS = MAX_WIDTH / NIBBLE_W;

  function automatic logic [NIBBLE_W-1:0] nibble_of(input logic [MAX_WIDTH-1:0] word,
                                                    input int idx);
    return word[NIBBLE_W*idx +: NIBBLE_W];
  endfunction

  // Bit i set when every nibble from i upward is zero; digit 0 is never blank.
  function automatic logic [MAX_DIGITS-1:0] lz_mask(input logic [MAX_WIDTH-1:0] word);
    logic [MAX_DIGITS-1:0] mask;
    logic                  seenNz;
    mask   = '0;
    seenNz = 1'b0;
    for (int i = MAX_DIGITS - 1; i > 0; i--) begin
      seenNz  = seenNz | (word[NIBBLE_W*i +: NIBBLE_W] != '0);
      mask[i] = ~seenNz;
    end
    return mask;
  endfunction

endpackage

// File: rtl/hex_display_scanner_refresh_tick_gen.sv
// Free-running divider producing a one-cycle tick every DIV clock cycles.
// With DIV=1 the counter never leaves 0 and tick is constantly high.
module refresh_tick_gen
  import hex_display_scanner_pkg::*;
#(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick  = (cnt_q == CNT_W'(DIV - 1));
  assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexes a captured word onto one shared 7-seg decoder input.
// New words wait in a pending register and are committed only when the scan wraps.
module hex_display_scanner
  import hex_display_scanner_pkg::*;
#(
  parameter  int WIDTH       = 16,
  parameter  int REFRESH_DIV = 50000,
  localparam int DIGITS      = WIDTH / 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              blank_lz,
  output logic [3:0]        nibble,
  output logic [DIGITS-1:0] digit_sel_n,
  output logic              digit_blank,
  output logic              frame_done
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic              tick;
  logic              wrap;

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0]  shown_q, shown_d;
  logic [WIDTH-1:0]  pending_q, pending_d;
  logic              pendValid_q, pendValid_d;

  logic [3:0]        nibble_q, nibble_d;
  logic [DIGITS-1:0] selN_q, selN_d;
  logic              blank_q, blank_d;
  logic              frameDone_q;
  logic [DIGITS-1:0] lzMask;

  refresh_tick_gen #(.DIV(REFRESH_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign wrap = tick && (idx_q == IDX_W'(DIGITS - 1));

  // A load on the wrap cycle commits directly; otherwise the last load of the frame waits.
  always_comb begin
    idx_d       = idx_q;
    shown_d     = shown_q;
    pending_d   = pending_q;
    pendValid_d = pendValid_q;
    if (tick) begin
      idx_d = wrap ? '0 : idx_q + IDX_W'(1);
    end
    if (wrap) begin
      shown_d     = load ? data_in : (pendValid_q ? pending_q : shown_q);
      pendValid_d = 1'b0;
    end else if (load) begin
      pending_d   = data_in;
      pendValid_d = 1'b1;
    end
  end

  // Outputs are derived from next-state values so they move on the same edge as idx.
  always_comb begin
    lzMask   = DIGITS'(lz_mask(MAX_WIDTH'(shown_d)));
    nibble_d = nibble_of(MAX_WIDTH'(shown_d), int'(idx_d));
    blank_d  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        blank_d = blank_lz & lzMask[i];
      end
    end
    selN_d = '1;
    for (int i = 0; i < DIGITS; i++) begin
      selN_d[i] = (idx_d != IDX_W'(i)) | blank_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q       <= '0;
      shown_q     <= '0;
      pending_q   <= '0;
      pendValid_q <= 1'b0;
      nibble_q    <= '0;
      selN_q      <= ~DIGITS'(1);
      blank_q     <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      shown_q     <= shown_d;
      pending_q   <= pending_d;
      pendValid_q <= pendValid_d;
      nibble_q    <= nibble_d;
      selN_q      <= selN_d;
      blank_q     <= blank_d;
      frameDone_q <= wrap;
    end
  end

  assign nibble      = nibble_q;
  assign digit_sel_n = selN_q;
  assign digit_blank = blank_q;
  assign frame_done  = frameDone_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Scoreboard bench: a frame-level reference model queues expected outputs per edge,
// monitors compare them against two scanner instances (REFRESH_DIV=4 and REFRESH_DIV=1).
module tb_hex_display_scanner;

  typedef struct {
    int          n;
    logic [15:0] shown;
    logic [15:0] pending;
    bit          pendValid;
  } mstate_t;

  typedef struct {
    logic [3:0] nib;
    logic [3:0] sel;
    bit         blank;
    bit         fd;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst4 = 1'b0, load4 = 1'b0, blz4 = 1'b0;
  logic [15:0] data4 = '0;
  logic [3:0]  nib4, sel4;
  logic        blk4, fd4;

  logic        rst1 = 1'b0, load1 = 1'b0, blz1 = 1'b0;
  logic [15:0] data1 = '0;
  logic [3:0]  nib1, sel1;
  logic        blk1, fd1;

  int checks   = 0;
  int failures = 0;

  mstate_t s4 = '{0, '0, '0, 1'b0};
  mstate_t s1 = '{0, '0, '0, 1'b0};
  exp_t    q4[$];
  exp_t    q1[$];

  hex_display_scanner #(.WIDTH(16), .REFRESH_DIV(4)) dut (
    .clk(clk), .reset(rst4), .load(load4), .data_in(data4), .blank_lz(blz4),
    .nibble(nib4), .digit_sel_n(sel4), .digit_blank(blk4), .frame_done(fd4)
  );

  hex_display_scanner #(.WIDTH(16), .REFRESH_DIV(1)) dut1 (
    .clk(clk), .reset(rst1), .load(load1), .data_in(data1), .blank_lz(blz1),
    .nibble(nib1), .digit_sel_n(sel1), .digit_blank(blk1), .frame_done(fd1)
  );

  // Reference: edge count since reset gives digit position and frame boundaries directly.
  function automatic void modelStep(input int div, input bit rst, input bit ld,
                                    input logic [15:0] d, input bit blz,
                                    input mstate_t s, output mstate_t ns, output exp_t e);
    int          idx;
    bit          wrap;
    logic [15:0] above;
    ns = s;
    if (rst) begin
      ns = '{0, '0, '0, 1'b0};
      e  = '{4'h0, 4'hE, 1'b0, 1'b0};
      return;
    end
    ns.n = s.n + 1;
    wrap = (ns.n % (div * 4)) == 0;
    if (wrap) begin
      ns.shown     = ld ? d : (s.pendValid ? s.pending : s.shown);
      ns.pendValid = 1'b0;
    end else if (ld) begin
      ns.pending   = d;
      ns.pendValid = 1'b1;
    end
    idx     = (ns.n / div) % 4;
    above   = ns.shown >> (4 * idx);
    e.nib   = above[3:0];
    e.blank = blz && (idx > 0) && (above == 16'h0);
    e.sel   = e.blank ? 4'hF : ~(4'b0001 << idx);
    e.fd    = wrap;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic applyStimulus(input bit ld, input logic [15:0] d, input bit blz);
    @(negedge clk);
    load4 = ld;
    data4 = d;
    blz4  = blz;
  endtask

  task automatic idle4(input int cycles, input bit blz);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 16'h0, blz);
  endtask

  // Returns just after a negedge where the coming edge number satisfies (n % 16) == phase.
  task automatic alignTo(input int phase);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      load4 = 1'b0;
      if (((s4.n + 1) % 16) == phase) return;
    end
    checkOutput("align_timeout", 32'd1, 32'd0);
  endtask

  initial begin : model4
    mstate_t ns;
    exp_t    e;
    forever begin
      @(posedge clk);
      modelStep(4, rst4, load4, data4, blz4, s4, ns, e);
      s4 = ns;
      q4.push_back(e);
    end
  end

  initial begin : model1
    mstate_t ns;
    exp_t    e;
    forever begin
      @(posedge clk);
      modelStep(1, rst1, load1, data1, blz1, s1, ns, e);
      s1 = ns;
      q1.push_back(e);
    end
  end

  initial begin : monitor4
    exp_t e;
    forever begin
      @(negedge clk);
      if (q4.size() > 0) begin
        e = q4.pop_front();
        checkOutput("div4_nibble", 32'(nib4), 32'(e.nib));
        checkOutput("div4_sel_n", 32'(sel4), 32'(e.sel));
        checkOutput("div4_blank", 32'(blk4), 32'(e.blank));
        checkOutput("div4_frame_done", 32'(fd4), 32'(e.fd));
      end
      checkOutput("div4_onehot_low", 32'($countones(~sel4) <= 1), 32'd1);
    end
  end

  initial begin : monitor1
    exp_t e;
    forever begin
      @(negedge clk);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        checkOutput("div1_nibble", 32'(nib1), 32'(e.nib));
        checkOutput("div1_sel_n", 32'(sel1), 32'(e.sel));
        checkOutput("div1_blank", 32'(blk1), 32'(e.blank));
        checkOutput("div1_frame_done", 32'(fd1), 32'(e.fd));
      end
      checkOutput("div1_onehot_low", 32'($countones(~sel1) <= 1), 32'd1);
    end
  end

  task automatic runDiv4();
    logic [15:0] masks [4];
    masks = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F};
    #1 rst4 = 1'b1;
    #1;
    checkOutput("reset_nibble", 32'(nib4), 32'h0);
    checkOutput("reset_sel_n", 32'(sel4), 32'hE);
    checkOutput("reset_blank", 32'(blk4), 32'h0);
    checkOutput("reset_frame_done", 32'(fd4), 32'h0);
    @(negedge clk);
    rst4 = 1'b0;

    applyStimulus(1'b1, 16'h1A2F, 1'b0);
    idle4(40, 1'b0);

    applyStimulus(1'b1, 16'h0040, 1'b1);
    idle4(36, 1'b1);
    applyStimulus(1'b1, 16'h0000, 1'b1);
    idle4(36, 1'b1);

    alignTo(1);
    load4 = 1'b1; data4 = 16'h1111; blz4 = 1'b0;
    idle4(3, 1'b0);
    applyStimulus(1'b1, 16'h2222, 1'b0);
    idle4(40, 1'b0);

    alignTo(0);
    load4 = 1'b1; data4 = 16'hBEEF; blz4 = 1'b0;
    idle4(40, 1'b0);

    alignTo(1);
    load4 = 1'b1; data4 = 16'hC0DE; blz4 = 1'b0;
    idle4(20, 1'b0);
    applyStimulus(1'b1, 16'h1234, 1'b1);
    idle4(3, 1'b1);
    @(negedge clk);
    load4 = 1'b0;
    #1 rst4 = 1'b1;
    #1;
    checkOutput("midreset_nibble", 32'(nib4), 32'h0);
    checkOutput("midreset_sel_n", 32'(sel4), 32'hE);
    checkOutput("midreset_blank", 32'(blk4), 32'h0);
    checkOutput("midreset_frame_done", 32'(fd4), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst4 = 1'b0;
    idle4(40, 1'b1);

    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom % 6) == 0, 16'($urandom) & masks[$urandom % 4],
                    1'($urandom % 2));
    end
    idle4(20, 1'b1);
  endtask

  task automatic runDiv1();
    #1 rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      load1 = ($urandom % 3) == 0;
      data1 = 16'($urandom) >> ($urandom % 16);
      blz1  = 1'($urandom % 2);
    end
    @(negedge clk);
    load1 = 1'b0;
  endtask

  initial begin
    fork
      runDiv4();
      runDiv1();
    join
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
